// File: rtl/run_sequencer_pkg.sv
// Shared definitions for the run sequencer and its users.
// Holds the state encoding, the default parameter values and a helper
// that sizes the hold counter.
package run_sequencer_pkg;

  // Encoding is fixed so that benches and the FW top can decode the state.
  typedef enum logic [2:0] {
    SEQ_HOLD    = 3'd0,
    SEQ_START   = 3'd1,
    SEQ_RUN     = 3'd2,
    SEQ_FINISH  = 3'd3,
    SEQ_TIMEOUT = 3'd4
  } seq_state_e;

  localparam int unsigned DEF_HOLD_CYCLES    = 4;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 1000;
  localparam int unsigned DEF_CNT_W          = 32;

  // Width of the hold counter for a given HOLD_CYCLES value.
  function automatic int unsigned hold_w(input int unsigned hold_cycles);
    return $clog2(hold_cycles) + 1;
  endfunction

endpackage

// File: rtl/run_sequencer_if.sv
// Control bundle between the run sequencer and the FW core / harness.
//   done, rerun        : core/harness -> sequencer
//   sys_reset, start   : sequencer -> core
//   busy, finished,
//   timeout,
//   cycle_count        : sequencer status
// master = sequencer side, slave = core/harness side.
interface run_sequencer_if
  import run_sequencer_pkg::*;
#(
  parameter int unsigned CNT_W = DEF_CNT_W
);

  logic             done;
  logic             rerun;
  logic             sys_reset;
  logic             start;
  logic             busy;
  logic             finished;
  logic             timeout;
  logic [CNT_W-1:0] cycle_count;

  modport master (
    input  done, rerun,
    output sys_reset, start, busy, finished, timeout, cycle_count
  );

  modport slave (
    output done, rerun,
    input  sys_reset, start, busy, finished, timeout, cycle_count
  );

endinterface

// File: rtl/run_sequencer.sv
// Run sequencer for the FW core: stretches the raw reset into a registered
// core reset, issues a one-cycle start pulse, measures the run length in
// cycles, stops a hung run with a watchdog and supports re-runs.
// Ports:
//   clk   : system clock, rising edge
//   reset : synchronous active-high reset
//   seq   : run_sequencer_if master modport (done/rerun in, status out)
module run_sequencer
  import run_sequencer_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES    = DEF_HOLD_CYCLES,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int unsigned CNT_W          = DEF_CNT_W
) (
  input  logic          clk,
  input  logic          reset,
  run_sequencer_if.master seq
);

  localparam int unsigned      HOLD_W      = hold_w(HOLD_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX    = '1;
  localparam logic [CNT_W-1:0]  CNT_LIMIT  = CNT_W'(TIMEOUT_CYCLES);
  localparam bit                WDOG_EN    = (TIMEOUT_CYCLES != 0);

  seq_state_e        state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              sys_reset_q, sys_reset_d;
  logic              start_q, start_d;
  logic              busy_q, busy_d;
  logic              finished_q, finished_d;
  logic              timeout_q, timeout_d;

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= SEQ_HOLD;
      hold_q      <= '0;
      cnt_q       <= '0;
      sys_reset_q <= 1'b1;
      start_q     <= 1'b0;
      busy_q      <= 1'b0;
      finished_q  <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      cnt_q       <= cnt_d;
      sys_reset_q <= sys_reset_d;
      start_q     <= start_d;
      busy_q      <= busy_d;
      finished_q  <= finished_d;
      timeout_q   <= timeout_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    cnt_d       = cnt_q;
    sys_reset_d = sys_reset_q;
    start_d     = 1'b0;
    busy_d      = busy_q;
    finished_d  = finished_q;
    timeout_d   = timeout_q;

    unique case (state_q)
      SEQ_HOLD: begin
        sys_reset_d = 1'b1;
        busy_d      = 1'b0;
        if (hold_q == HOLD_LAST) begin
          state_d     = SEQ_START;
          hold_d      = '0;
          sys_reset_d = 1'b0;
          start_d     = 1'b1;
          busy_d      = 1'b1;
          cnt_d       = '0;
        end else begin
          hold_d = HOLD_W'(hold_q + 1'b1);
        end
      end

      // done is deliberately not looked at during the start cycle.
      SEQ_START: begin
        state_d = SEQ_RUN;
        cnt_d   = CNT_W'(1);
      end

      // done has priority over the watchdog on the same edge.
      SEQ_RUN: begin
        if (seq.done) begin
          state_d    = SEQ_FINISH;
          busy_d     = 1'b0;
          finished_d = 1'b1;
        end else if (WDOG_EN && (cnt_q == CNT_LIMIT)) begin
          state_d     = SEQ_TIMEOUT;
          busy_d      = 1'b0;
          timeout_d   = 1'b1;
          sys_reset_d = 1'b1;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = CNT_W'(cnt_q + 1'b1);
        end
      end

      // cycle_count is left alone on rerun; the next start clears it.
      SEQ_FINISH, SEQ_TIMEOUT: begin
        if (seq.rerun) begin
          state_d     = SEQ_HOLD;
          hold_d      = '0;
          sys_reset_d = 1'b1;
          finished_d  = 1'b0;
          timeout_d   = 1'b0;
        end
      end

      default: begin
        state_d     = SEQ_HOLD;
        hold_d      = '0;
        sys_reset_d = 1'b1;
        busy_d      = 1'b0;
      end
    endcase
  end

  assign seq.sys_reset   = sys_reset_q;
  assign seq.start       = start_q;
  assign seq.busy        = busy_q;
  assign seq.finished    = finished_q;
  assign seq.timeout     = timeout_q;
  assign seq.cycle_count = cnt_q;

endmodule
